// File: rtl/rs_latch_arb_pkg.sv
// Shared types and sizing helpers for the RS latch arbiter.
package rs_latch_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PULSE  = 2'd1,
        SETTLE = 2'd2,
        CHECK  = 2'd3
    } state_e;

    // Bits needed to index n items; never returns less than 1.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rs_latch_arb_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or after pointer, wrapping.
module rr_arbiter
    import rs_latch_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] pointer,
    output logic [N_REQ-1:0] gnt_next,
    output logic [IDX_W-1:0] index,
    output logic             valid
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_next = '0;
        index    = '0;
        valid    = 1'b0;
        sum      = '0;
        cand     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            // pointer and k are both below N_REQ, so one subtraction wraps
            sum = {1'b0, pointer} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(N_REQ))
                sum = sum - (IDX_W+1)'(N_REQ);
            cand = sum[IDX_W-1:0];
            if (!valid && req[cand]) begin
                valid          = 1'b1;
                index          = cand;
                gnt_next[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rs_latch_arbiter.sv
// Shares one external RS latch between N_REQ requesters: round-robin grant,
// width-controlled s/r pulse, settle, then synchronised q readback.
//
//   state  | meaning
//   IDLE   | waiting for any req; arbiter picks the next requester
//   PULSE  | driving s (set) or r (reset) for PULSE_CYCLES cycles
//   SETTLE | s=r=0, waiting for latch settle plus synchroniser delay
//   CHECK  | one cycle: done, err if synchronised q differs from target
module rs_latch_arbiter
    import rs_latch_arb_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int PULSE_CYCLES  = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] op,
    output logic [N_REQ-1:0] gnt,
    output logic             done,
    output logic             err,
    output logic             busy,
    output logic             r,
    output logic             s,
    input  logic             q
);

    localparam int IDX_W   = idx_width(N_REQ);
    localparam int CNT_MAX = (PULSE_CYCLES > SETTLE_CYCLES + 1) ? PULSE_CYCLES : SETTLE_CYCLES + 1;
    localparam int CNT_W   = idx_width(CNT_MAX + 1);

    state_e           state, state_nxt;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] idx;
    logic             tgt;
    logic [CNT_W-1:0] cnt;
    logic             q_meta, q_sync;

    logic [N_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0] arb_index;
    logic             arb_valid;
    logic             cnt_zero;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req      (req),
        .pointer  (ptr),
        .gnt_next (arb_gnt),
        .index    (arb_index),
        .valid    (arb_valid)
    );

    assign cnt_zero = (cnt == '0);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arb_valid) state_nxt = PULSE;
            PULSE:   if (cnt_zero)  state_nxt = SETTLE;
            SETTLE:  if (cnt_zero)  state_nxt = CHECK;
            CHECK:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        busy = (state != IDLE);
        done = (state == CHECK);
        err  = (state == CHECK) && (q_sync != tgt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= '0;
            idx    <= '0;
            tgt    <= 1'b0;
            cnt    <= '0;
            gnt    <= '0;
            r      <= 1'b0;
            s      <= 1'b0;
            q_meta <= 1'b0;
            q_sync <= 1'b0;
        end else begin
            state  <= state_nxt;
            q_meta <= q;
            q_sync <= q_meta;
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        idx <= arb_index;
                        tgt <= op[arb_index];
                        gnt <= arb_gnt;
                        cnt <= CNT_W'(PULSE_CYCLES - 1);
                        s   <= op[arb_index];
                        r   <= ~op[arb_index];
                    end
                end
                PULSE: begin
                    if (cnt_zero) begin
                        // settle count includes the two synchroniser stages
                        cnt <= CNT_W'(SETTLE_CYCLES + 1);
                        s   <= 1'b0;
                        r   <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SETTLE: begin
                    if (!cnt_zero)
                        cnt <= cnt - 1'b1;
                end
                CHECK: begin
                    gnt <= '0;
                    ptr <= (idx == IDX_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    a_rs_exclusive: assert property (@(posedge clk) disable iff (rst) !(r && s));

endmodule

// File: tb/tb_rs_latch_arbiter.sv
// Self-checking bench: scoreboard of expected grants/err, latch behavioural model.
module tb_rs_latch_arbiter;

    localparam int N  = 4;
    localparam int P1 = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] op  = '0;
    logic [N-1:0] gnt;
    logic         done, err, busy, r, s;
    logic         q = 1'b0;
    logic         fault = 1'b0;

    logic [N-1:0] req_b = '0;
    logic [N-1:0] op_b  = '0;
    logic [N-1:0] gnt_b;
    logic         done_b, err_b, busy_b, r_b, s_b;
    logic         q_b = 1'b0;

    typedef struct {
        int   idx;
        logic tgt;
        logic err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   ptr_m  = 0;

    rs_latch_arbiter #(.N_REQ(N), .PULSE_CYCLES(P1), .SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .req(req), .op(op), .gnt(gnt), .done(done),
        .err(err), .busy(busy), .r(r), .s(s), .q(q)
    );

    rs_latch_arbiter #(.N_REQ(N), .PULSE_CYCLES(1), .SETTLE_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .op(op_b), .gnt(gnt_b), .done(done_b),
        .err(err_b), .busy(busy_b), .r(r_b), .s(s_b), .q(q_b)
    );

    always #5 clk = ~clk;

    // Behavioural RS latches; fault pins the first one low.
    always @(s or r or fault) begin
        if (fault)  q = 1'b0;
        else if (s) q = 1'b1;
        else if (r) q = 1'b0;
    end

    always @(s_b or r_b) begin
        if (s_b)      q_b = 1'b1;
        else if (r_b) q_b = 1'b0;
    end

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ((r & s) !== 1'b0 || (r_b & s_b) !== 1'b0) begin
                errors++;
                $display("FAIL rs_exclusive: r&s=%b r_b&s_b=%b, required 0", r & s, r_b & s_b);
            end
        end
    end

    function automatic int rr_pick(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++) begin
            if (m[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic test_reset();
        #2 rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({gnt, done, err, busy, r, s} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: gnt=%b done=%b err=%b busy=%b r=%b s=%b, required all 0",
                     gnt, done, err, busy, r, s);
        end
        @(negedge clk);
        rst = 1'b0;
        ptr_m = 0;
        @(posedge clk); @(negedge clk);
        checks++;
        if (busy !== 1'b0 || gnt !== '0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b gnt=%b, required 0", busy, gnt);
        end
    endtask

    task automatic run_op(input int idx, input logic opv, input string name);
        exp_t e, x;
        logic qexp;
        bit   seen;
        qexp  = fault ? 1'b0 : opv;
        e.idx = idx;
        e.tgt = opv;
        e.err = (qexp != opv);
        sb.push_back(e);
        req[idx] = 1'b1;
        op[idx]  = opv;
        seen = 0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(posedge clk); @(negedge clk);
            if (k == 2) op[idx] = ~opv;
            checks++;
            if (gnt !== onehot(idx)) begin
                errors++;
                $display("FAIL %s gnt c%0d: got %b, required %b", name, k, gnt, onehot(idx));
            end
            checks++;
            if (k <= P1) begin
                if ({s, r} !== {opv, ~opv}) begin
                    errors++;
                    $display("FAIL %s pulse c%0d: s=%b r=%b, required s=%b r=%b", name, k, s, r, opv, ~opv);
                end
            end else if ({s, r} !== 2'b00) begin
                errors++;
                $display("FAIL %s quiet c%0d: s=%b r=%b, required 0 0", name, k, s, r);
            end
            if (done === 1'b1) begin
                seen = 1;
                x = sb.pop_front();
                checks++;
                if (k !== 6) begin
                    errors++;
                    $display("FAIL %s latency: done at cycle %0d, required 6", name, k);
                end
                checks++;
                if (gnt !== onehot(x.idx) || err !== x.err) begin
                    errors++;
                    $display("FAIL %s result: gnt=%b err=%b, required gnt=%b err=%b",
                             name, gnt, err, onehot(x.idx), x.err);
                end
                ptr_m = (x.idx + 1) % N;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: no done within 20 cycles", name);
            sb.delete();
        end
        req[idx] = 1'b0;
        @(posedge clk); @(negedge clk);
        checks++;
        if (gnt !== '0 || done !== 1'b0 || busy !== 1'b0 || q !== qexp) begin
            errors++;
            $display("FAIL %s after: gnt=%b done=%b busy=%b q=%b, required 0 0 0 q=%b",
                     name, gnt, done, busy, q, qexp);
        end
    endtask

    task automatic test_contention();
        logic [N-1:0] m;
        exp_t e, x;
        int   p, c, cyc, last;
        op  = 4'b0101;
        req = 4'b1111;
        m = req;
        p = ptr_m;
        for (int i = 0; i < N; i++) begin
            c = rr_pick(m, p);
            e.idx = c; e.tgt = op[c]; e.err = 1'b0;
            sb.push_back(e);
            m[c] = 1'b0;
            p = (c + 1) % N;
        end
        cyc = 0;
        last = -1;
        while (sb.size() > 0 && cyc < 200) begin
            @(posedge clk); @(negedge clk);
            cyc++;
            if (done === 1'b1) begin
                x = sb.pop_front();
                checks++;
                if (gnt !== onehot(x.idx) || err !== x.err) begin
                    errors++;
                    $display("FAIL contention order: gnt=%b err=%b, required gnt=%b err=%b",
                             gnt, err, onehot(x.idx), x.err);
                end
                if (last >= 0) begin
                    checks++;
                    if (cyc - last !== 7) begin
                        errors++;
                        $display("FAIL contention spacing: %0d cycles, required 7", cyc - last);
                    end
                end
                last = cyc;
                req[x.idx] = 1'b0;
                ptr_m = (x.idx + 1) % N;
            end
        end
        checks++;
        if (sb.size() != 0 || q !== 1'b0) begin
            errors++;
            $display("FAIL contention end: pending=%0d q=%b, required 0 pending q=0", sb.size(), q);
            sb.delete();
        end
        req = '0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_fault();
        fault = 1'b1;
        run_op(1, 1'b1, "fault_set");
        run_op(0, 1'b0, "fault_next");
        fault = 1'b0;
    endtask

    task automatic test_reset_mid_pulse();
        req[3] = 1'b1;
        op[3]  = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++;
        if (s !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst pre: s=%b busy=%b, required 1 1", s, busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({r, s, gnt, busy} !== '0) begin
            errors++;
            $display("FAIL midrst async: r=%b s=%b gnt=%b busy=%b, required all 0", r, s, gnt, busy);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ptr_m = 0;
        run_op(3, 1'b1, "midrst_regrant");
    endtask

    task automatic test_sweep();
        exp_t e, x;
        bit   seen;
        int   s_cnt;
        e.idx = 0; e.tgt = 1'b1; e.err = 1'b0;
        sb.push_back(e);
        req_b[0] = 1'b1;
        op_b[0]  = 1'b1;
        seen  = 0;
        s_cnt = 0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(posedge clk); @(negedge clk);
            if (s_b === 1'b1) s_cnt++;
            if (k == 1) begin
                checks++;
                if (s_b !== 1'b1 || r_b !== 1'b0) begin
                    errors++;
                    $display("FAIL sweep pulse: s=%b r=%b at c1, required 1 0", s_b, r_b);
                end
            end
            if (done_b === 1'b1) begin
                seen = 1;
                x = sb.pop_front();
                checks++;
                if (k !== 4 || gnt_b !== onehot(x.idx) || err_b !== x.err) begin
                    errors++;
                    $display("FAIL sweep done: cycle %0d gnt=%b err=%b, required cycle 4 gnt=%b err=%b",
                             k, gnt_b, err_b, onehot(x.idx), x.err);
                end
            end
        end
        checks++;
        if (!seen || s_cnt !== 1 || q_b !== 1'b1) begin
            errors++;
            $display("FAIL sweep width: seen=%0d s_cycles=%0d q=%b, required 1 1 1", seen, s_cnt, q_b);
            sb.delete();
        end
        req_b = '0;
        @(posedge clk); @(negedge clk);
    endtask

    initial begin
        test_reset();
        run_op(0, 1'b1, "single_set");
        run_op(2, 1'b0, "single_reset");
        test_reset();
        test_contention();
        test_fault();
        test_reset_mid_pulse();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
